// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange node array and its sequencer.
package replica_pkg;
  localparam int CITY_NUM = 16;
  localparam int OPT_NUM  = 4;
  localparam int OPT_W    = $clog2(OPT_NUM);

  typedef logic [OPT_W-1:0] opt_command_t;

  typedef enum logic [1:0] {
    DIST_IDLE  = 2'd0,
    DIST_START = 2'd1
  } distance_command_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RAND, S_RAND_W, S_DIST, S_DIST_W, S_MTR, S_MTR_W,
    S_REPL, S_REPL_W, S_EXCH, S_EXCH_W
  } seq_state_t;

  localparam int RAND_LAT_DEF = 4;
  localparam int DIST_LAT_DEF = 16;
  localparam int MTR_LAT_DEF  = 4;
  localparam int REPL_LAT_DEF = 4;
  localparam int EXCH_LAT_DEF = CITY_NUM;
endpackage

// File: rtl/opt_rotate.sv
// Next enabled opt index after cur_i, searching upward with wrap; cur_i itself is the last candidate.
module opt_rotate
  import replica_pkg::*;
(
  input  logic [OPT_NUM-1:0] mask_i,
  input  opt_command_t       cur_i,
  output opt_command_t       nxt_o
);
  opt_command_t idx;

  // Walk from farthest to nearest so the nearest enabled index wins.
  always_comb begin
    nxt_o = cur_i;
    idx   = cur_i;
    for (int i = OPT_NUM; i >= 1; i--) begin
      idx = opt_command_t'((int'(cur_i) + i) % OPT_NUM);
      if (mask_i[idx]) nxt_o = idx;
    end
  end
endmodule

// File: rtl/anneal_seq.sv
// Per-iteration strobe sequencer for the node chain: rand, distance, metropolis, replica, exchange.
module anneal_seq
  import replica_pkg::*;
#(
  parameter int RAND_LAT = RAND_LAT_DEF,
  parameter int DIST_LAT = DIST_LAT_DEF,
  parameter int MTR_LAT  = MTR_LAT_DEF,
  parameter int REPL_LAT = REPL_LAT_DEF,
  parameter int EXCH_LAT = EXCH_LAT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        iter_num,
  input  logic [OPT_NUM-1:0] opt_mask,
  output logic               busy,
  output logic               done,
  output logic [31:0]        iter_cnt,
  output opt_command_t       opt_command,
  output logic               random_run,
  output distance_command_t  distance_com,
  output logic               metropolis_run,
  output logic               replica_run,
  output logic               exchange_run,
  output logic               exchange_bank
);
  localparam int CNT_W = 16;

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        iter_num_q, iter_num_d;
  logic [31:0]        iter_cnt_q, iter_cnt_d;
  logic [OPT_NUM-1:0] mask_q, mask_d;
  opt_command_t       opt_q, opt_d;
  logic               bank_q, bank_d;
  logic               done_q, done_d;
  logic               busy_q, rand_q, mtr_q, repl_q, exch_q;
  distance_command_t  dist_q;

  logic [OPT_NUM-1:0] mask_eff, rot_mask;
  opt_command_t       rot_cur, rot_nxt;
  logic               iter_end;

  // An empty mask falls back to opt 0 only.
  assign mask_eff = (opt_mask == '0) ? OPT_NUM'(1) : opt_mask;
  // In IDLE, searching from the top index yields the lowest enabled opt.
  assign rot_mask = (state_q == S_IDLE) ? mask_eff : mask_q;
  assign rot_cur  = (state_q == S_IDLE) ? opt_command_t'(OPT_NUM - 1) : opt_q;

  opt_rotate u_rot (.mask_i(rot_mask), .cur_i(rot_cur), .nxt_o(rot_nxt));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iter_num_d = iter_num_q;
    iter_cnt_d = iter_cnt_q;
    mask_d     = mask_q;
    opt_d      = opt_q;
    bank_d     = bank_q;
    done_d     = 1'b0;
    iter_end   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start && !abort) begin
        if (iter_num == '0) done_d = 1'b1;
        else begin
          state_d    = S_RAND;
          iter_num_d = iter_num;
          mask_d     = mask_eff;
          iter_cnt_d = '0;
          opt_d      = rot_nxt;
        end
      end
      S_RAND: begin
        state_d = (RAND_LAT == 0) ? S_DIST : S_RAND_W;
        cnt_d   = CNT_W'(RAND_LAT - 1);
      end
      S_RAND_W: if (cnt_q == '0) state_d = S_DIST; else cnt_d = cnt_q - 1'b1;
      S_DIST: begin
        state_d = (DIST_LAT == 0) ? S_MTR : S_DIST_W;
        cnt_d   = CNT_W'(DIST_LAT - 1);
      end
      S_DIST_W: if (cnt_q == '0) state_d = S_MTR; else cnt_d = cnt_q - 1'b1;
      S_MTR: begin
        state_d = (MTR_LAT == 0) ? S_REPL : S_MTR_W;
        cnt_d   = CNT_W'(MTR_LAT - 1);
      end
      S_MTR_W: if (cnt_q == '0) state_d = S_REPL; else cnt_d = cnt_q - 1'b1;
      S_REPL: begin
        state_d = (REPL_LAT == 0) ? S_EXCH : S_REPL_W;
        cnt_d   = CNT_W'(REPL_LAT - 1);
      end
      S_REPL_W: if (cnt_q == '0) state_d = S_EXCH; else cnt_d = cnt_q - 1'b1;
      S_EXCH: begin
        if (EXCH_LAT == 0) iter_end = 1'b1;
        else state_d = S_EXCH_W;
        cnt_d = CNT_W'(EXCH_LAT - 1);
      end
      S_EXCH_W: if (cnt_q == '0) iter_end = 1'b1; else cnt_d = cnt_q - 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (iter_end) begin
      bank_d     = ~bank_q;
      iter_cnt_d = iter_cnt_q + 32'd1;
      opt_d      = rot_nxt;
      if (iter_cnt_q + 32'd1 == iter_num_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RAND;
      end
    end

    // Abort freezes progress state; only the sequence itself is dropped.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      bank_d     = bank_q;
      iter_cnt_d = iter_cnt_q;
      opt_d      = opt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      iter_num_q <= '0;
      iter_cnt_q <= '0;
      mask_q     <= '0;
      opt_q      <= '0;
      bank_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rand_q     <= 1'b0;
      dist_q     <= DIST_IDLE;
      mtr_q      <= 1'b0;
      repl_q     <= 1'b0;
      exch_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_num_q <= iter_num_d;
      iter_cnt_q <= iter_cnt_d;
      mask_q     <= mask_d;
      opt_q      <= opt_d;
      bank_q     <= bank_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE);
      rand_q     <= (state_d == S_RAND);
      dist_q     <= (state_d == S_DIST) ? DIST_START : DIST_IDLE;
      mtr_q      <= (state_d == S_MTR);
      repl_q     <= (state_d == S_REPL);
      exch_q     <= (state_d == S_EXCH);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign iter_cnt       = iter_cnt_q;
  assign opt_command    = opt_q;
  assign exchange_bank  = bank_q;
  assign random_run     = rand_q;
  assign distance_com   = dist_q;
  assign metropolis_run = mtr_q;
  assign replica_run    = repl_q;
  assign exchange_run   = exch_q;
endmodule

// File: tb/tb_anneal_seq.sv
// Directed bench for anneal_seq: latencies 2/3/1/2/4 (period 17) plus a DIST_LAT=0 build (period 14).
module tb_anneal_seq;
  import replica_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, start0, abort0;
  logic [31:0] iter_num, iter_num0;
  logic [OPT_NUM-1:0] opt_mask, opt_mask0;

  logic busy, done, random_run, metropolis_run, replica_run, exchange_run, exchange_bank;
  logic [31:0] iter_cnt;
  opt_command_t opt_command;
  distance_command_t distance_com;

  logic busy0, done0, random_run0, metropolis_run0, replica_run0, exchange_run0, exchange_bank0;
  logic [31:0] iter_cnt0;
  opt_command_t opt_command0;
  distance_command_t distance_com0;

  int ntests = 0;
  int nfail  = 0;

  anneal_seq #(.RAND_LAT(2), .DIST_LAT(3), .MTR_LAT(1), .REPL_LAT(2), .EXCH_LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .iter_num(iter_num),
    .opt_mask(opt_mask), .busy(busy), .done(done), .iter_cnt(iter_cnt),
    .opt_command(opt_command), .random_run(random_run), .distance_com(distance_com),
    .metropolis_run(metropolis_run), .replica_run(replica_run),
    .exchange_run(exchange_run), .exchange_bank(exchange_bank));

  anneal_seq #(.RAND_LAT(2), .DIST_LAT(0), .MTR_LAT(1), .REPL_LAT(2), .EXCH_LAT(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0), .iter_num(iter_num0),
    .opt_mask(opt_mask0), .busy(busy0), .done(done0), .iter_cnt(iter_cnt0),
    .opt_command(opt_command0), .random_run(random_run0), .distance_com(distance_com0),
    .metropolis_run(metropolis_run0), .replica_run(replica_run0),
    .exchange_run(exchange_run0), .exchange_bank(exchange_bank0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {random, dist_start, metropolis, replica, exchange, done, busy} expected at cycle c after start.
  function automatic logic [6:0] exp_vec(int c, int n, int per, int od, int om, int orp, int oe);
    int ph;
    ph = (c - 1) % per;
    if (c <= n * per)
      return {ph == 0, ph == od, ph == om, ph == orp, ph == oe, 1'b0, 1'b1};
    if (c == n * per + 1) return 7'b0000010;
    return 7'b0;
  endfunction

  function automatic logic [6:0] vec();
    return {random_run, distance_com == DIST_START, metropolis_run, replica_run,
            exchange_run, done, busy};
  endfunction

  function automatic logic [6:0] vec0();
    return {random_run0, distance_com0 == DIST_START, metropolis_run0, replica_run0,
            exchange_run0, done0, busy0};
  endfunction

  task automatic pulse_start(input int n, input logic [OPT_NUM-1:0] m);
    iter_num = n; opt_mask = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; iter_num = '0; opt_mask = '0;
    start0 = 1'b0; abort0 = 1'b0; iter_num0 = '0; opt_mask0 = '0;
    tick(); tick();
    reset = 1'b0;

    chk("reset_vec", 32'(vec()), 32'h0);
    chk("reset_dist", 32'(distance_com), 32'(DIST_IDLE));
    chk("reset_cnt", iter_cnt, 32'd0);
    chk("reset_bank", 32'(exchange_bank), 32'd0);
    chk("reset_opt", 32'(opt_command), 32'd0);

    // Single iteration
    pulse_start(1, 4'b0001);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      chk($sformatf("one_c%0d", c), 32'(vec()), 32'(exp_vec(c, 1, 17, 3, 7, 9, 12)));
    end
    chk("one_bank", 32'(exchange_bank), 32'd1);
    chk("one_cnt", iter_cnt, 32'd1);

    // Three iterations, mask 0b101: opt 0,2,0; bank 0,1,0,1
    do_reset();
    pulse_start(3, 4'b0101);
    for (int c = 1; c <= 52; c++) begin
      if (c > 1) tick();
      chk($sformatf("three_c%0d", c), 32'(vec()), 32'(exp_vec(c, 3, 17, 3, 7, 9, 12)));
      if (c <= 51) begin
        chk($sformatf("three_opt_c%0d", c), 32'(opt_command), ((c - 1) / 17 == 1) ? 32'd2 : 32'd0);
        chk($sformatf("three_bank_c%0d", c), 32'(exchange_bank), 32'(((c - 1) / 17) % 2));
        chk($sformatf("three_cnt_c%0d", c), iter_cnt, 32'((c - 1) / 17));
      end
    end
    chk("three_bank_end", 32'(exchange_bank), 32'd1);
    chk("three_cnt_end", iter_cnt, 32'd3);

    // Zero iterations
    pulse_start(0, 4'b0001);
    chk("zero_c1", 32'(vec()), 32'b0000010);
    tick();
    chk("zero_c2", 32'(vec()), 32'h0);

    // Abort in DIST_W of iteration 2 of 5
    do_reset();
    pulse_start(5, 4'b0001);
    for (int c = 2; c <= 22; c++) tick();
    chk("abort_pre_c22", 32'(vec()), 32'(exp_vec(22, 5, 17, 3, 7, 9, 12)));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_vec", 32'(vec()), 32'h0);
    chk("abort_cnt", iter_cnt, 32'd1);
    chk("abort_bank", 32'(exchange_bank), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", k), 32'(vec()), 32'h0);
    end
    abort = 1'b1; start = 1'b1; iter_num = 32'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", 32'(vec()), 32'h0);
    tick();
    pulse_start(1, 4'b0001);
    chk("resume_rand", 32'(random_run), 32'd1);
    chk("resume_bank", 32'(exchange_bank), 32'd1);
    for (int c = 2; c <= 18; c++) tick();
    chk("resume_done", 32'(vec()), 32'b0000010);
    chk("resume_bank_end", 32'(exchange_bank), 32'd0);
    chk("resume_cnt", iter_cnt, 32'd1);

    // Reset during EXCH_W of iteration 2
    do_reset();
    pulse_start(2, 4'b0010);
    for (int c = 2; c <= 32; c++) tick();
    chk("rst_pre_bank", 32'(exchange_bank), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_vec", 32'(vec()), 32'h0);
    chk("rst_cnt", iter_cnt, 32'd0);
    chk("rst_bank", 32'(exchange_bank), 32'd0);
    chk("rst_opt", 32'(opt_command), 32'd0);
    chk("rst_dist", 32'(distance_com), 32'(DIST_IDLE));

    // Start while busy is ignored
    tick();
    pulse_start(2, 4'b0001);
    for (int c = 2; c <= 5; c++) tick();
    iter_num = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 7; c <= 34; c++) tick();
    chk("busy_start_c34", 32'(vec()), 32'(exp_vec(34, 2, 17, 3, 7, 9, 12)));
    tick();
    chk("busy_start_done", 32'(vec()), 32'b0000010);
    chk("busy_start_cnt", iter_cnt, 32'd2);

    // DIST_LAT = 0 build: period 14
    iter_num0 = 32'd2; opt_mask0 = 4'b0001; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 29; c++) begin
      if (c > 1) tick();
      chk($sformatf("nodist_c%0d", c), 32'(vec0()), 32'(exp_vec(c, 2, 14, 3, 4, 6, 9)));
    end
    chk("nodist_cnt", iter_cnt0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/anneal_seq.md
# anneal_seq

Per-iteration sequencer for the replica-exchange node array. It issues the ordered strobes that every `node` instance consumes in lock-step for each annealing iteration: random, delta distance, metropolis, replica test and exchange. It sits between the host/register block and the node chain. It owns the iteration count, opt-command rotation and `exchange_bank` toggling, and it reports busy/done to the host.

## Interface
Parameters:
- `RAND_LAT`, default 4: wait cycles after `random_run`.
- `DIST_LAT`, default 16: wait cycles after the distance start command.
- `MTR_LAT`, default 4: wait cycles after `metropolis_run`.
- `REPL_LAT`, default 4: wait cycles after `replica_run`.
- `EXCH_LAT`, default `city_num`: wait cycles after `exchange_run` (ordering copy).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; accepted only in IDLE.
- `abort` in 1: level; stops the sequence at the next clock.
- `iter_num` in 32: iterations to run, latched on start.
- `opt_mask` in `OPT_NUM`: enabled opt commands, latched on start.
- `busy` out 1: high from the cycle after an accepted start until the return to IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `iter_cnt` out 32: completed iterations in the current run.
- `opt_command` out `opt_command_t`: current opt mode, broadcast to the nodes.
- `random_run` out 1: one-cycle strobe.
- `distance_com` out `distance_command_t`: `DIST_START` for one cycle, `DIST_IDLE` otherwise.
- `metropolis_run` out 1: one-cycle strobe.
- `replica_run` out 1: one-cycle strobe.
- `exchange_run` out 1: one-cycle strobe.
- `exchange_bank` out 1: ordering bank select.

## Operation
- States: IDLE, RAND, RAND_W, DIST, DIST_W, MTR, MTR_W, REPL, REPL_W, EXCH, EXCH_W.
- Each X state lasts 1 cycle and asserts its strobe. Its X_W state then waits exactly X_LAT cycles, counted by a shared down-counter loaded on entry.
- A latency parameter of 0 skips the X_W state.
- IDLE + start with `iter_num` != 0: latch inputs, clear `iter_cnt`, select the first enabled opt, go to RAND.
- IDLE + start with `iter_num` == 0: pulse `done` next cycle and stay in IDLE.
- `opt_mask` == 0 at start: treated as a mask containing only the lowest opt command (opt index 0).
- End of EXCH_W:
  - Toggle `exchange_bank` and increment `iter_cnt`.
  - Advance `opt_command` to the next enabled opt in ascending index order, wrapping around.
  - If `iter_cnt` + 1 == `iter_num`: go to IDLE and pulse `done` in the same cycle `busy` falls. Otherwise go to RAND.
- `opt_command` changes only at an iteration boundary. It is stable from RAND through EXCH_W.
- abort in any non-IDLE state: next state is IDLE, all strobes low, no `done`. `exchange_bank` and `iter_cnt` keep their values.
- abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, start is ignored.
- start while busy is ignored.
- `iter_cnt` saturates nowhere. It never exceeds `iter_num`, which is 32 bits wide.

## Timing
- Reset values: state IDLE; `busy`, `done`, all strobes 0; `distance_com` = `DIST_IDLE`; `iter_cnt` 0; `exchange_bank` 0; `opt_command` = opt index 0.
- All outputs are registered (Moore), and strobes are exactly one cycle wide.
- `random_run` rises 1 cycle after an accepted start.
- Iteration period = 5 + RAND_LAT + DIST_LAT + MTR_LAT + REPL_LAT + EXCH_LAT cycles.
- The `exchange_bank` toggle is visible in the first RAND cycle of the next iteration.
- Reset asserted mid-run returns to reset values on the next edge, regardless of state.

## Structure
- `replica_pkg` additions:
  - `seq_state_t` enum.
  - `OPT_NUM`.
  - `DIST_START` / `DIST_IDLE` encodings of `distance_command_t`.
  - The latency defaults.
- Sub-module `opt_rotate`: given the mask and the current index, it returns the next enabled index (priority search with wrap). It is purely combinational and about 30 lines.
- FSM, wait counter and iteration counter stay in `anneal_seq`.

## Test plan
Use RAND/DIST/MTR/REPL/EXCH_LAT = 2/3/1/2/4, so the period is 17.
- start, `iter_num` = 1 → `random_run`@1, `distance_com`@4, `metropolis_run`@8, `replica_run`@10, `exchange_run`@13; `done`@18 with `busy` low; `exchange_bank` = 1, `iter_cnt` = 1.
- `iter_num` = 3, `opt_mask` = 0b101 → `opt_command` sequence 0, 2, 0; `exchange_bank` 0→1→0→1; `done` exactly 51 cycles after `random_run`@1.
- `iter_num` = 0 → `done` 1 cycle after start, `busy` never high, no strobes.
- abort asserted in DIST_W of iteration 2 of 5 → IDLE next cycle, no `done`, `iter_cnt` = 1, `exchange_bank` = 1; a new start then resumes with bank 1.
- reset pulsed during EXCH_W → all outputs at reset values the following cycle; start pulsed during busy → ignored, `done` timing unchanged.
- DIST_LAT = 0 build → DIST_W skipped, period 14.
